// File: rtl/cache_arbiter.sv
// Two-port round-robin arbiter in front of a single-ported cache: one command
// in flight at a time, with timeout abort and saturating per-port miss counters.
module cache_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              wr0,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              miss0,
  output logic              miss1,
  output logic              err0,
  output logic              err1,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_valid,
  input  logic              mem_response,
  input  logic              mem_miss,
  input  logic [DATA_W-1:0] mem_out,
  output logic [CNT_W-1:0]  miss_cnt0,
  output logic [CNT_W-1:0]  miss_cnt1,
  output logic              busy
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             state;
  state_t             state_next;
  logic               grant;      // port owning the outstanding command
  logic               prio;       // port preferred when both request
  logic               has_last;   // a previous command exists to compare against
  logic               last_wr;    // un-toggled wr of the current/previous command
  logic [TMR_W-1:0]   timer;
  logic [TMR_W-1:0]   timer_inc;

  logic               start;
  logic               pick;
  logic               sel_wr;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               cmd_same;
  logic               resp_ok;
  logic               timed_out;

  assign timer_inc = timer + TMR_W'(1);

  // Winner selection and command mux; only meaningful while in IDLE.
  assign pick     = (req0 && req1) ? prio : req1;
  assign sel_wr   = pick ? wr1   : wr0;
  assign sel_addr = pick ? addr1 : addr0;
  assign sel_data = pick ? data1 : data0;

  // mem_addr/mem_data still hold the previous command, so compare against them.
  assign cmd_same = has_last && (sel_wr == last_wr) &&
                    (sel_addr == mem_addr) && (sel_data == mem_data);

  // NOTE: every signal driven here gets a default before the case statement;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    resp_ok    = 1'b0;
    timed_out  = 1'b0;
    case (state)
      S_IDLE: begin
        if (req0 || req1) begin
          start      = 1'b1;
          state_next = S_ISSUE;
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        // A response in the last allowed cycle still wins over the abort.
        if (mem_response) begin
          resp_ok    = 1'b1;
          state_next = S_DONE;
        end else if (timer_inc == TMR_W'(TIMEOUT)) begin
          timed_out  = 1'b1;
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Command side: grant, mem_* lines, round-robin pointer and WAIT timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant     <= 1'b0;
      prio      <= 1'b0;
      has_last  <= 1'b0;
      last_wr   <= 1'b0;
      timer     <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_data  <= '0;
      mem_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      // Registered from the next state so both line up exactly with the FSM.
      mem_valid <= (state_next == S_ISSUE) || (state_next == S_WAIT);
      busy      <= (state_next != S_IDLE);
      if (start) begin
        grant    <= pick;
        mem_addr <= sel_addr;
        mem_data <= sel_data;
        // A repeat of the previous command flips wr for the ISSUE cycle only,
        // so the cache still sees an edge on its command lines.
        mem_wr   <= sel_wr ^ cmd_same;
        last_wr  <= sel_wr;
        has_last <= 1'b1;
      end
      if (state == S_ISSUE) mem_wr <= last_wr;
      if (state == S_WAIT)  timer  <= timer_inc;
      if (state == S_DONE) begin
        prio  <= ~grant;
        timer <= '0;
      end
    end
  end

  // Response side: per-port ack/rdata/miss/err and saturating miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      miss0     <= 1'b0;
      miss1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      miss_cnt0 <= '0;
      miss_cnt1 <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (resp_ok || timed_out) begin
        if (!grant) begin
          ack0   <= 1'b1;
          rdata0 <= resp_ok ? mem_out : '0;
          miss0  <= resp_ok & mem_miss;
          err0   <= timed_out;
        end else begin
          ack1   <= 1'b1;
          rdata1 <= resp_ok ? mem_out : '0;
          miss1  <= resp_ok & mem_miss;
          err1   <= timed_out;
        end
      end
      if (state == S_DONE) begin
        if (!grant && miss0 && !err0 && !(&miss_cnt0))
          miss_cnt0 <= miss_cnt0 + CNT_W'(1);
        if (grant && miss1 && !err1 && !(&miss_cnt1))
          miss_cnt1 <= miss_cnt1 + CNT_W'(1);
      end
    end
  end

endmodule
